bmp_frame_writer: RTL
=====================

Name: bmp_frame_writer

Overview:
- Receive-side counterpart of the sharpening filter's RGB pixel stream.
- Accepts one RGB pixel per cycle (r/g/b plus a per-cycle done/valid strobe) and packs the pixels into BMP pixel-array byte order: B,G,R per pixel, rows padded to a 4-byte boundary.
- Emits 32-bit word writes to a frame memory from which the host reads the processed image.
- Tracks column and row position, inserts row padding, and flags frame completion and input overruns.

Parameters:
- WIDTH, 8, bits per colour component; fixed at 8, any other value unsupported.
- COLS, 3840, pixels per image line.
- ROWS, 2160, lines per frame.
- ADDR_BITS, 23, width of the word address.
- BASE_ADDR, 0, word address of the first pixel-array word of each frame.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset; 0 = reset
- r_data_in  in  WIDTH  red component
- g_data_in  in  WIDTH  green component
- b_data_in  in  WIDTH  blue component
- data_in_done  in  1  pixel valid this cycle
- in_ready  out  1  block can accept a pixel this cycle
- mem_we  out  1  word write strobe
- mem_addr  out  ADDR_BITS  word address
- mem_wdata  out  32  packed word; byte0 = bits[7:0] = earliest byte in stream
- frame_done  out  1  one-cycle pulse coincident with the last word write of a frame
- overflow  out  1  sticky: a pixel arrived while in_ready=0

Behaviour:
- Reset (reset=0 at a clk edge) gives: in_ready=1, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, frame_done=0, overflow=0. The byte accumulator is emptied and the column/row counters are zeroed.
- Reset asserted mid-frame discards all partial data; the next accepted pixel is column 0, row 0.
- Derived constants:
  - ROW_BYTES = 3*COLS
  - PAD = (4 - ROW_BYTES mod 4) mod 4
  - WORDS_PER_ROW = (ROW_BYTES + PAD)/4
- A pixel is accepted at an edge where data_in_done=1 and in_ready=1. It appends bytes b, g, r, in that order, to the accumulator (0..3 bytes held).
- Word output:
  - When the accumulator reaches 4 or more bytes, the oldest 4 bytes form a word.
  - mem_we=1 with that word and the current address is visible in the cycle after the accepting edge; the address then increments by 1.
  - At most one word per accepted pixel; the accumulator holds 0..3 bytes after each step.
  - mem_we is 0 in any cycle with no new word; mem_addr and mem_wdata hold their last values.
- State machine RUN / FLUSH:
  - RUN: accepts pixels; the column counter counts 0..COLS-1.
  - When the last pixel of a row (col=COLS-1) is accepted and PAD!=0, go to FLUSH for exactly one cycle with in_ready=0.
  - FLUSH: leftover bytes are zero-padded to a full word, which is written with mem_we=1 in the following cycle; the accumulator is emptied; return to RUN.
  - With PAD=0 the accumulator is empty at row end; FLUSH is never entered and in_ready stays 1.
  - Every row starts word-aligned at BASE_ADDR + row*WORDS_PER_ROW.
- Row and frame:
  - The row counter increments at row end.
  - On the final word of row ROWS-1, frame_done=1 in the same cycle as that mem_we.
  - Counters and the address return to BASE_ADDR for the next frame with no idle cycle required.
- Gaps: idle cycles between pixels (data_in_done=0) are allowed anywhere and do not change the output word sequence.
- Overrun: data_in_done=1 while in_ready=0 drops the pixel (counters unchanged) and sets overflow=1 until reset.

Test Plan:
- COLS=3, ROWS=2, BASE_ADDR=0x10; pixels (R,G,B) = (11,12,13), (21,22,23), (31,32,33) on consecutive edges c0..c2. Required response:
  - word 0x23111213 @0x10 visible c1+1
  - word 0x32332122 @0x11 visible c2+1
  - in_ready=0 in that same cycle
  - word 0x00000031 @0x12 one cycle later
  - row 2 writes to 0x13..0x15 with frame_done=1 on the 0x15 write
- COLS=4, ROWS=1, pixels 01..0C (B,G,R per pixel in turn) -> words @0,1,2 are 0x04030201, 0x08070605, 0x0C0B0A09; in_ready never 0; frame_done on the third write.
- Overrun with COLS=3: drive data_in_done=1 during the FLUSH cycle -> overflow=1 and stays 1; the dropped pixel does not appear; the next row's first word still lands at 0x13.
- Reset=0 after 2 pixels of row 1 -> outputs return to reset values; the following frame starts at BASE_ADDR with identical words to the clean run.
- Two back-to-back frames (COLS=3, ROWS=2) with random 0-3 cycle gaps between pixels -> same 6 words per frame at 0x10..0x15 each frame; frame_done pulses exactly twice; overflow=0.

Source files
------------

// File: rtl/bmp_frame_writer.sv
// Packs an RGB pixel stream into BMP pixel-array order (B,G,R, rows padded to 4 bytes)
// and writes 32-bit words to frame memory, flagging frame completion and input overruns.
module bmp_frame_writer #(
  parameter int          WIDTH     = 8,
  parameter int          COLS      = 3840,
  parameter int          ROWS      = 2160,
  parameter int          ADDR_BITS = 23,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     r_data_in,
  input  logic [WIDTH-1:0]     g_data_in,
  input  logic [WIDTH-1:0]     b_data_in,
  input  logic                 data_in_done,
  output logic                 in_ready,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [31:0]          mem_wdata,
  output logic                 frame_done,
  output logic                 overflow
);

  // Handshake: a pixel is taken on a rising edge where data_in_done=1 and in_ready=1;
  // data_in_done=1 with in_ready=0 drops the pixel and latches overflow.

  localparam int ROW_BYTES = 3 * COLS;
  localparam int PAD       = (4 - (ROW_BYTES % 4)) % 4;
  localparam bit HAS_PAD   = (PAD != 0);
  localparam int CW        = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW        = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [ADDR_BITS-1:0] BASE = ADDR_BITS'(BASE_ADDR);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t state, state_next;

  logic [CW-1:0]        col;
  logic [RW-1:0]        row;
  logic [23:0]          acc;
  logic [1:0]           acc_cnt;
  logic                 flush_last;
  logic [ADDR_BITS-1:0] wr_addr;

  logic        accept;
  logic        col_last;
  logic        is_last;
  logic [23:0] pix;
  logic [47:0] ext;
  logic [2:0]  tot;
  logic [2:0]  tot_m4;
  logic        wr_en;
  logic [31:0] wr_word;
  logic        wr_last;
  logic [23:0] acc_d;
  logic [1:0]  acc_cnt_d;

  assign in_ready = (state == RUN);
  assign accept   = data_in_done && in_ready;
  assign col_last = (col == CW'(COLS - 1));
  assign is_last  = col_last && (row == RW'(ROWS - 1));
  assign pix      = {r_data_in, g_data_in, b_data_in};

  // Blue lands in the lowest free byte so byte0 of each word is the oldest stream byte.
  assign ext    = {24'b0, acc} | ({24'b0, pix} << {acc_cnt, 3'b000});
  assign tot    = {1'b0, acc_cnt} + 3'd3;
  assign tot_m4 = tot - 3'd4;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (accept && col_last && HAS_PAD) state_next = FLUSH;
      FLUSH:   state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    wr_en     = 1'b0;
    wr_word   = 32'h0;
    wr_last   = 1'b0;
    acc_d     = acc;
    acc_cnt_d = acc_cnt;
    if (state == FLUSH) begin
      wr_en     = 1'b1;
      wr_word   = {8'h00, acc};
      wr_last   = flush_last;
      acc_d     = 24'h0;
      acc_cnt_d = 2'd0;
    end else if (accept) begin
      if (tot >= 3'd4) begin
        wr_en     = 1'b1;
        wr_word   = ext[31:0];
        wr_last   = !HAS_PAD && is_last;
        acc_d     = {8'h00, ext[47:32]};
        acc_cnt_d = tot_m4[1:0];
      end else begin
        acc_d     = ext[23:0];
        acc_cnt_d = tot[1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      col        <= '0;
      row        <= '0;
      acc        <= 24'h0;
      acc_cnt    <= 2'd0;
      flush_last <= 1'b0;
      wr_addr    <= BASE;
      mem_we     <= 1'b0;
      mem_addr   <= BASE;
      mem_wdata  <= 32'h0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      mem_we     <= wr_en;
      frame_done <= wr_en && wr_last;
      acc        <= acc_d;
      acc_cnt    <= acc_cnt_d;
      if (data_in_done && !in_ready) overflow <= 1'b1;
      if (wr_en) begin
        mem_addr  <= wr_addr;
        mem_wdata <= wr_word;
        wr_addr   <= wr_last ? BASE : wr_addr + 1'b1;
      end
      if (accept) begin
        if (col_last) begin
          col        <= '0;
          row        <= (row == RW'(ROWS - 1)) ? '0 : row + 1'b1;
          flush_last <= is_last;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

endmodule
